ram_port_arbiter: RTL

- Round-robin arbiter that shares one port of the 16x8 dual-port RAM between three requesters.
- After reset, the block first clears the whole RAM to zero. It then grants at most one access per cycle.
- Its RAM-side ports connect directly to one RAM port (we, addr, din, dout); the other RAM port stays free for the consumer.

---
 rtl/ram_port_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Round-robin arbiter that gives three requesters shared use of one port of
//   a 2**ADDR_W x DATA_W dual-port RAM. After reset it first writes zero to
//   every RAM location (INIT). It then grants at most one access per cycle
//   (RUN). All RAM-side outputs are registered.
//
//   Optional build macro: ARB_GRANT_CNT_EN adds saturating 8-bit per-requester
//   grant counters (grant_cnt0..2). Arbitration is the same in both builds.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   req        per-requester request, bit i = requester i
//   req_we     per-requester write enable, valid while req[i] is high
//   req_addr   flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata  flattened write data, requester i at [i*DATA_W +: DATA_W]
//   ack        one-hot: requester i's access is on the RAM port this cycle
//   rvalid     one-hot: rdata holds requester i's read result
//   rdata      read data, taken straight from ram_dout
//   init_done  high once RAM clearing has finished
//   ram_we     RAM write enable (registered)
//   ram_addr   RAM address (registered)
//   ram_din    RAM write data (registered)
//   ram_dout   RAM registered read data
//   grant_cnt0..2 (ARB_GRANT_CNT_EN only) saturating ack counts per requester
module ram_port_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            req,
  input  logic [2:0]            req_we,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [3*DATA_W-1:0]   req_wdata,
  output logic [2:0]            ack,
  output logic [2:0]            rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic                  init_done,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_din,
  input  logic [DATA_W-1:0]     ram_dout
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [7:0]            grant_cnt0,
  output logic [7:0]            grant_cnt1,
  output logic [7:0]            grant_cnt2
`endif
);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [1:0]          last_q, last_d;

  logic [2:0]          ack_d;
  logic [2:0]          rvalid_d;
  logic                init_done_d;
  logic                ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_d;
  logic [DATA_W-1:0]   ram_din_d;

  logic                grant_valid;
  logic [1:0]          win;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [2:0]          win_onehot;

  assign rdata = ram_dout;

  // Round-robin pick: search upward from last+1, wrapping modulo 3.
  always_comb begin
    grant_valid = |req;
    win         = 2'd0;
    case (last_q)
      2'd0:    win = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    win = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    sel_we     = 1'b0;
    sel_addr   = '0;
    sel_wdata  = '0;
    win_onehot = '0;
    case (win)
      2'd0: begin
        sel_we     = req_we[0];
        sel_addr   = req_addr[0 +: ADDR_W];
        sel_wdata  = req_wdata[0 +: DATA_W];
        win_onehot = 3'b001;
      end
      2'd1: begin
        sel_we     = req_we[1];
        sel_addr   = req_addr[ADDR_W +: ADDR_W];
        sel_wdata  = req_wdata[DATA_W +: DATA_W];
        win_onehot = 3'b010;
      end
      default: begin
        sel_we     = req_we[2];
        sel_addr   = req_addr[2*ADDR_W +: ADDR_W];
        sel_wdata  = req_wdata[2*DATA_W +: DATA_W];
        win_onehot = 3'b100;
      end
    endcase
  end

  // Next-state and next-output logic; every output register is loaded from
  // here so the RAM port sees clean registered signals.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    ack_d       = '0;
    rvalid_d    = '0;
    init_done_d = init_done;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr;
    ram_din_d   = ram_din;

    case (state_q)
      INIT: begin
        ram_we_d    = 1'b1;
        ram_din_d   = '0;
        ram_addr_d  = cnt_q;
        cnt_d       = cnt_q + 1'b1;
        init_done_d = 1'b0;
        if (cnt_q == '1) begin
          state_d = RUN;
        end
      end
      default: begin
        init_done_d = 1'b1;
        // Read result appears one cycle after the access; writes are masked
        // using the ram_we that went out with that access.
        rvalid_d    = ack & {3{~ram_we}};
        if (grant_valid) begin
          ram_we_d   = sel_we;
          ram_addr_d = sel_addr;
          ram_din_d  = sel_wdata;
          ack_d      = win_onehot;
          last_d     = win;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INIT;
      cnt_q     <= '0;
      last_q    <= 2'd2;
      ack       <= '0;
      rvalid    <= '0;
      init_done <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      ack       <= ack_d;
      rvalid    <= rvalid_d;
      init_done <= init_done_d;
      ram_we    <= ram_we_d;
      ram_addr  <= ram_addr_d;
      ram_din   <= ram_din_d;
    end
  end

`ifdef ARB_GRANT_CNT_EN
  logic grant_run;
  assign grant_run = (state_q == RUN) && grant_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
      grant_cnt2 <= '0;
    end else if (grant_run) begin
      if (win == 2'd0 && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + 8'd1;
      if (win == 2'd1 && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + 8'd1;
      if (win == 2'd2 && grant_cnt2 != '1) grant_cnt2 <= grant_cnt2 + 8'd1;
    end
  end
`endif

endmodule
